// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples an asynchronous 7-bit segment bus, filters it
// for stability, and decodes each settled glyph back to a BCD digit.
// Optional feature macro: SEVEN_SEG_HEX_DECODE_EN adds the hex glyphs A..F to
// the legal table; without it those glyphs are reported as errors.
//
// state  | meaning
// SETTLE | candidate glyph changed recently, counting identical samples
// LOCKED | candidate held long enough; committed, waiting for next change

module seven_segment_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       update,
  output logic       error
);

  localparam int            CW        = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]    RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {SETTLE, LOCKED} state_t;

  logic [6:0]    sync_q [SYNC_STAGES];
  logic [6:0]    seg_s;
  state_t        state, state_nxt;
  logic [6:0]    cand, cand_nxt;
  logic [6:0]    committed;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          commit;
  logic          dec_legal;
  logic [3:0]    dec_digit;

  // Synchronizer chain for the asynchronous segment bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RAW_BLANK;
    end else begin
      sync_q[0] <= seg_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Everything downstream sees lit segments as 1.
  assign seg_s = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // FSM state, candidate glyph and stability counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      cand  <= 7'h00;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: any change restarts the filter; a full count locks and commits
  // only when the glyph differs from the last committed one.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    if (seg_s != cand) begin
      cand_nxt  = seg_s;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_MAX) begin
        state_nxt = LOCKED;
        commit    = (cand != committed);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Glyph decode of the candidate (active-high, g..a).
  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'h0;
    case (cand)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
`ifdef SEVEN_SEG_HEX_DECODE_EN
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // Commit register: outputs change only on a commit edge; pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= 7'h00;
      bcd       <= 4'h0;
      valid     <= 1'b0;
      update    <= 1'b0;
      error     <= 1'b0;
    end else begin
      update <= 1'b0;
      error  <= 1'b0;
      if (commit) begin
        committed <= cand;
        if (dec_legal) begin
          bcd    <= dec_digit;
          valid  <= 1'b1;
          update <= 1'b1;
        end else if (cand == 7'h00) begin
          valid <= 1'b0;
        end else begin
          valid <= 1'b0;
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: expected pulses are queued when a glyph is
// driven and matched against DUT pulses, including the cycle they appear in.

module tb_seven_segment_capture;

  localparam int LAT  = 2 + 16 + 1;
  localparam int HOLD = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] bcd;
  logic       valid, update, error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_err;
    logic [3:0] bcd;
    logic       valid;
    int         at;
  } ev_t;
  ev_t sb[$];

  logic [6:0] m_committed;
  logic [3:0] m_bcd;
  logic       m_valid;
  logic [6:0] tbl [16];

  seven_segment_capture dut (
    .clk(clk), .rst(rst), .seg_in(seg_in),
    .bcd(bcd), .valid(valid), .update(update), .error(error)
  );

  always #5 clk = ~clk;

  // Posedge counter used to timestamp pulses.
  always @(posedge clk) cyc++;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Match each observed pulse against the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (update || error)) begin
      check_eq("excl", {31'd0, update & error}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, update, error}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check_eq("kind_err", {31'd0, error}, {31'd0, e.is_err});
        check_eq("kind_upd", {31'd0, update}, {31'd0, ~e.is_err});
        check_eq("ev_bcd", {28'd0, bcd}, {28'd0, e.bcd});
        check_eq("ev_valid", {31'd0, valid}, {31'd0, e.valid});
        check_eq("ev_cycle", cyc, e.at);
      end
    end
  end

  function automatic logic [4:0] tb_decode(logic [6:0] g);
    int n;
    n = 10;
`ifdef SEVEN_SEG_HEX_DECODE_EN
    n = 16;
`endif
    for (int i = 0; i < n; i++)
      if (tbl[i] == g) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(string tag);
    check_eq({tag, "_pending"}, sb.size(), 32'd0);
    check_eq({tag, "_bcd"}, {28'd0, bcd}, {28'd0, m_bcd});
    check_eq({tag, "_valid"}, {31'd0, valid}, {31'd0, m_valid});
  endtask

  // Drive a raw (active-low) glyph, predict the commit, let it settle, check.
  task automatic apply(string tag, logic [6:0] raw);
    logic [6:0] g;
    logic [4:0] d;
    ev_t e;
    @(negedge clk);
    seg_in = raw;
    g = ~raw;
    if (g != m_committed) begin
      d = tb_decode(g);
      m_committed = g;
      if (d[4]) begin
        m_bcd = d[3:0]; m_valid = 1'b1;
        e.is_err = 1'b0; e.bcd = m_bcd; e.valid = 1'b1; e.at = cyc + LAT;
        sb.push_back(e);
      end else if (g == 7'h00) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b0;
        e.is_err = 1'b1; e.bcd = m_bcd; e.valid = 1'b0; e.at = cyc + LAT;
        sb.push_back(e);
      end
    end
    hold(HOLD);
    check_state(tag);
  endtask

  // Short excursion to another glyph and back: must produce nothing.
  task automatic glitch(string tag, logic [6:0] raw, int n);
    logic [6:0] back;
    back = seg_in;
    @(negedge clk);
    seg_in = raw;
    hold(n);
    seg_in = back;
    hold(HOLD);
    check_state(tag);
  endtask

  initial begin
    ev_t e;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_committed = 7'h00; m_bcd = 4'h0; m_valid = 1'b0;

    rst = 1'b1;
    seg_in = 7'h7F;
    hold(3);
    check_eq("rst_bcd", {28'd0, bcd}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_pulses", {30'd0, update, error}, 32'd0);
    rst = 1'b0;
    hold(40);
    check_state("blank_idle");

    apply("digit3", 7'h30);
    glitch("glitch10", 7'h40, 10);
    glitch("glitch15", 7'h40, 15);
    apply("illegal_e", 7'h6F);
    apply("hex_E", 7'h06);

    for (int d = 0; d < 10; d++) begin
      logic [6:0] code;
      code = tbl[d];
      apply($sformatf("digit%0d_loop", d), ~code);
    end
    apply("hex_A", 7'h08);
    apply("digit9_again", 7'h10);
    apply("blank", 7'h7F);

    // Reset in the middle of settling on "7".
    @(negedge clk);
    seg_in = 7'h78;
    hold(13);
    rst = 1'b1;
    hold(2);
    check_eq("midrst_bcd", {28'd0, bcd}, 32'd0);
    check_eq("midrst_valid", {31'd0, valid}, 32'd0);
    check_eq("midrst_pending", sb.size(), 32'd0);
    rst = 1'b0;
    m_committed = 7'h07; m_bcd = 4'h7; m_valid = 1'b1;
    e.is_err = 1'b0; e.bcd = 4'h7; e.valid = 1'b1; e.at = cyc + LAT;
    sb.push_back(e);
    hold(HOLD);
    check_state("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
